// File: rtl/neighbor_best_hop_selector.sv
// Best next-hop selector: walks the neighbor table once per request and keeps the valid entry
// with the highest Q-value (ties: fewest CH hops, then lowest index). Optional macro: NBR_SEL_ENERGY_FILTER_EN.
module neighbor_best_hop_selector #(
  parameter int WORD_WIDTH  = 16,
  parameter int TABLE_DEPTH = 32,
  parameter int IDX_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [IDX_WIDTH-1:0]  rd_idx,
  input  logic                  rd_valid,
  input  logic [WORD_WIDTH-1:0] rd_node_id,
  input  logic [WORD_WIDTH-1:0] rd_hops,
  input  logic [WORD_WIDTH-1:0] rd_qvalue,
  input  logic [WORD_WIDTH-1:0] rd_energy,
  input  logic [WORD_WIDTH-1:0] rd_ch_hops,
`ifdef NBR_SEL_ENERGY_FILTER_EN
  input  logic [WORD_WIDTH-1:0] min_energy,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [IDX_WIDTH-1:0]  best_idx,
  output logic [WORD_WIDTH-1:0] best_id,
  output logic [WORD_WIDTH-1:0] best_qvalue,
  output logic [WORD_WIDTH-1:0] best_ch_hops
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_WIDTH-1:0]  r_cnt;
  logic                  r_run_found;
  logic [WORD_WIDTH-1:0] r_run_q, r_run_ch, r_run_id;
  logic [IDX_WIDTH-1:0]  r_run_idx;
  logic                  r_done, r_found;
  logic [IDX_WIDTH-1:0]  r_best_idx;
  logic [WORD_WIDTH-1:0] r_best_id, r_best_q, r_best_ch;

  logic                  w_last, w_elig, w_take, w_nxt_found;
  logic [WORD_WIDTH-1:0] w_nxt_q, w_nxt_ch, w_nxt_id;
  logic [IDX_WIDTH-1:0]  w_nxt_idx;
  logic                  w_unused;

`ifdef NBR_SEL_ENERGY_FILTER_EN
  assign w_elig   = rd_valid && (rd_energy >= min_energy);
  assign w_unused = ^rd_hops;
`else
  assign w_elig   = rd_valid;
  assign w_unused = ^{rd_hops, rd_energy};
`endif

  assign w_last = (r_cnt == IDX_WIDTH'(TABLE_DEPTH - 1));
  // Strict compares only, so a full tie keeps the earlier (lower) index.
  assign w_take = w_elig && (!r_run_found || (rd_qvalue > r_run_q) ||
                             ((rd_qvalue == r_run_q) && (rd_ch_hops < r_run_ch)));

  assign w_nxt_found = r_run_found | w_take;
  assign w_nxt_q     = w_take ? rd_qvalue  : r_run_q;
  assign w_nxt_ch    = w_take ? rd_ch_hops : r_run_ch;
  assign w_nxt_id    = w_take ? rd_node_id : r_run_id;
  assign w_nxt_idx   = w_take ? r_cnt      : r_run_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && !abort) w_state_nxt = S_SCAN;
      S_SCAN:  if (abort) w_state_nxt = S_IDLE;
               else if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_run_found <= 1'b0;
      r_run_q     <= '0;
      r_run_ch    <= '1;
      r_run_id    <= '0;
      r_run_idx   <= '0;
      r_done      <= 1'b0;
      r_found     <= 1'b0;
      r_best_idx  <= '0;
      r_best_id   <= '0;
      r_best_q    <= '0;
      r_best_ch   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_cnt       <= '0;
            r_run_found <= 1'b0;
            r_run_q     <= '0;
            r_run_ch    <= '1;
            r_run_id    <= '0;
            r_run_idx   <= '0;
          end
        end
        S_SCAN: begin
          if (!abort) begin
            r_cnt       <= r_cnt + IDX_WIDTH'(1);
            r_run_found <= w_nxt_found;
            r_run_q     <= w_nxt_q;
            r_run_ch    <= w_nxt_ch;
            r_run_id    <= w_nxt_id;
            r_run_idx   <= w_nxt_idx;
            // Publish on the final sample so the result is visible alongside done.
            if (w_last) begin
              r_done     <= 1'b1;
              r_found    <= w_nxt_found;
              r_best_idx <= w_nxt_found ? w_nxt_idx : '0;
              r_best_id  <= w_nxt_found ? w_nxt_id  : '0;
              r_best_q   <= w_nxt_found ? w_nxt_q   : '0;
              r_best_ch  <= w_nxt_found ? w_nxt_ch  : '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_idx       = (r_state == S_SCAN) ? r_cnt : '0;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign found        = r_found;
  assign best_idx     = r_best_idx;
  assign best_id      = r_best_id;
  assign best_qvalue  = r_best_q;
  assign best_ch_hops = r_best_ch;

endmodule

// File: tb/tb_neighbor_best_hop_selector.sv
// Directed bench for neighbor_best_hop_selector; the energy test expects idx5 when built
// with NBR_SEL_ENERGY_FILTER_EN and idx2 otherwise.
module tb_neighbor_best_hop_selector;

  localparam int W = 16;
  localparam int D = 32;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [IW-1:0] rd_idx;
  logic rd_valid;
  logic [W-1:0] rd_node_id, rd_hops, rd_qvalue, rd_energy, rd_ch_hops, min_energy;
  logic busy, done, found;
  logic [IW-1:0] best_idx;
  logic [W-1:0] best_id, best_qvalue, best_ch_hops;

  logic          t_valid [D];
  logic [W-1:0]  t_q     [D];
  logic [W-1:0]  t_ch    [D];
  logic [W-1:0]  t_en    [D];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rd_valid   = t_valid[rd_idx];
  assign rd_node_id = 16'h1000 + 16'(rd_idx);
  assign rd_hops    = 16'(rd_idx) + 16'd7;
  assign rd_qvalue  = t_q[rd_idx];
  assign rd_energy  = t_en[rd_idx];
  assign rd_ch_hops = t_ch[rd_idx];

  neighbor_best_hop_selector #(.WORD_WIDTH(W), .TABLE_DEPTH(D), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_node_id(rd_node_id), .rd_hops(rd_hops),
    .rd_qvalue(rd_qvalue), .rd_energy(rd_energy), .rd_ch_hops(rd_ch_hops),
`ifdef NBR_SEL_ENERGY_FILTER_EN
    .min_energy(min_energy),
`endif
    .busy(busy), .done(done), .found(found), .best_idx(best_idx), .best_id(best_id),
    .best_qvalue(best_qvalue), .best_ch_hops(best_ch_hops)
  );

  task automatic clear_table();
    for (int i = 0; i < D; i++) begin
      t_valid[i] = 1'b0;
      t_q[i]     = 16'h7777;
      t_ch[i]    = 16'd0;
      t_en[i]    = 16'hFFFF;
    end
  endtask

  task automatic load_basic();
    clear_table();
    t_valid[3]  = 1'b1; t_q[3]  = 16'h0040; t_ch[3]  = 16'd3;
    t_valid[7]  = 1'b1; t_q[7]  = 16'h0080; t_ch[7]  = 16'd5;
    t_valid[20] = 1'b1; t_q[20] = 16'h0080; t_ch[20] = 16'd2;
  endtask

  // Called #1 after a rising edge with the DUT idle; returns in the done cycle.
  // done is expected D edges after the edge sampling start (33 cycles after the start cycle).
  task automatic do_scan(output int cyc, output bit timeout);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    timeout = 1'b0;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 100) timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; min_energy = 16'h0000;
    clear_table();
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || rd_idx !== 5'd0) begin
      errors++; $display("FAIL reset_ctrl got busy=%b done=%b found=%b rd_idx=%0d exp 0 0 0 0", busy, done, found, rd_idx);
    end
    checks++; if (best_idx !== 5'd0 || best_id !== 16'd0 || best_qvalue !== 16'd0 || best_ch_hops !== 16'd0) begin
      errors++; $display("FAIL reset_best got %0d %h %h %h exp all 0", best_idx, best_id, best_qvalue, best_ch_hops);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int cyc; bit to;
    load_basic();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || rd_idx !== 5'd0) begin
      errors++; $display("FAIL basic_busy_rise got busy=%b rd_idx=%0d exp 1 0", busy, rd_idx);
    end
    cyc = 0; to = 1'b0;
    while (done !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (cyc >= 100) to = 1'b1;
    checks++; if (to || cyc != D) begin
      errors++; $display("FAIL basic_latency got %0d exp %0d", cyc, D);
    end
    checks++; if (found !== 1'b1 || best_idx !== 5'd20 || best_id !== 16'h1014) begin
      errors++; $display("FAIL basic_idx got found=%b idx=%0d id=%h exp 1 20 1014", found, best_idx, best_id);
    end
    checks++; if (best_qvalue !== 16'h0080 || best_ch_hops !== 16'd2) begin
      errors++; $display("FAIL basic_q_ch got q=%h ch=%0d exp 0080 2", best_qvalue, best_ch_hops);
    end
    checks++; if (busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy_done got %b exp 1", busy);
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_after_done got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_reset_mid_scan();
    int ndone = 0;
    load_basic();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (rd_idx !== 5'd10 || busy !== 1'b1) begin
      errors++; $display("FAIL midrst_pre got rd_idx=%0d busy=%b exp 10 1", rd_idx, busy);
    end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || rd_idx !== 5'd0 || done !== 1'b0 || found !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl got busy=%b rd_idx=%0d done=%b found=%b exp 0 0 0 0", busy, rd_idx, done, found);
    end
    checks++; if (best_idx !== 5'd0 || best_id !== 16'd0 || best_qvalue !== 16'd0 || best_ch_hops !== 16'd0) begin
      errors++; $display("FAIL midrst_best got %0d %h %h %h exp all 0", best_idx, best_id, best_qvalue, best_ch_hops);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin
      errors++; $display("FAIL midrst_no_done got %0d active cycles exp 0", ndone);
    end
  endtask

  task automatic test_tie();
    int cyc; bit to;
    clear_table();
    t_valid[4] = 1'b1; t_q[4] = 16'h0100; t_ch[4] = 16'd1;
    t_valid[9] = 1'b1; t_q[9] = 16'h0100; t_ch[9] = 16'd1;
    do_scan(cyc, to);
    checks++; if (to || cyc != D) begin
      errors++; $display("FAIL tie_latency got %0d exp %0d", cyc, D);
    end
    checks++; if (found !== 1'b1 || best_idx !== 5'd4 || best_id !== 16'h1004 || best_qvalue !== 16'h0100 || best_ch_hops !== 16'd1) begin
      errors++; $display("FAIL tie_result got found=%b idx=%0d id=%h q=%h ch=%0d exp 1 4 1004 0100 1", found, best_idx, best_id, best_qvalue, best_ch_hops);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int ndone = 0;
    load_basic();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks++; if (rd_idx !== 5'd12) begin
      errors++; $display("FAIL abort_idx got %0d exp 12", rd_idx);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || rd_idx !== 5'd0) begin
      errors++; $display("FAIL abort_idle got busy=%b rd_idx=%0d exp 0 0", busy, rd_idx);
    end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin
      errors++; $display("FAIL abort_no_done got %0d exp 0", ndone);
    end
    checks++; if (found !== 1'b1 || best_idx !== 5'd4 || best_qvalue !== 16'h0100 || best_ch_hops !== 16'd1) begin
      errors++; $display("FAIL abort_hold got found=%b idx=%0d q=%h ch=%0d exp 1 4 0100 1", found, best_idx, best_qvalue, best_ch_hops);
    end
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL abort_prio_start got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_start_ignored();
    int ndone = 0;
    bit at32 = 1'b0;
    load_basic();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      start = (c == 5);
      if (done === 1'b1) ndone++;
      if (c == 32) at32 = done;
      if (c == 10) begin
        checks++; if (best_idx !== 5'd4 || best_qvalue !== 16'h0100) begin
          errors++; $display("FAIL scan_hold got idx=%0d q=%h exp 4 0100", best_idx, best_qvalue);
        end
      end
    end
    checks++; if (ndone != 1 || at32 !== 1'b1) begin
      errors++; $display("FAIL start_ignored got %0d dones (at edge 32: %b) exp 1 (1)", ndone, at32);
    end
    checks++; if (best_idx !== 5'd20 || best_ch_hops !== 16'd2) begin
      errors++; $display("FAIL start_ignored_res got idx=%0d ch=%0d exp 20 2", best_idx, best_ch_hops);
    end
  endtask

  task automatic test_none();
    int cyc; bit to;
    clear_table();
    do_scan(cyc, to);
    checks++; if (to || cyc != D) begin
      errors++; $display("FAIL none_latency got %0d exp %0d", cyc, D);
    end
    checks++; if (found !== 1'b0 || best_idx !== 5'd0 || best_id !== 16'd0 || best_qvalue !== 16'd0 || best_ch_hops !== 16'd0) begin
      errors++; $display("FAIL none_result got found=%b %0d %h %h %h exp all 0", found, best_idx, best_id, best_qvalue, best_ch_hops);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_energy();
    int cyc; bit to;
    logic [IW-1:0] exp_idx;
    clear_table();
    min_energy = 16'h0200;
    t_valid[2] = 1'b1; t_q[2] = 16'h00F0; t_en[2] = 16'h0100; t_ch[2] = 16'd4;
    t_valid[5] = 1'b1; t_q[5] = 16'h0010; t_en[5] = 16'h0300; t_ch[5] = 16'd6;
`ifdef NBR_SEL_ENERGY_FILTER_EN
    exp_idx = 5'd5;
`else
    exp_idx = 5'd2;
`endif
    do_scan(cyc, to);
    checks++; if (to || cyc != D) begin
      errors++; $display("FAIL energy_latency got %0d exp %0d", cyc, D);
    end
    checks++; if (found !== 1'b1 || best_idx !== exp_idx || best_id !== (16'h1000 + 16'(exp_idx)) || best_ch_hops !== ((exp_idx == 5'd5) ? 16'd6 : 16'd4)) begin
      errors++; $display("FAIL energy_result got found=%b idx=%0d id=%h ch=%0d exp idx %0d", found, best_idx, best_id, best_ch_hops, exp_idx);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc; bit to;
    clear_table();
    t_valid[31] = 1'b1; t_q[31] = 16'h0000; t_ch[31] = 16'hFFFF;
    do_scan(cyc, to);
    checks++; if (to || found !== 1'b1 || best_idx !== 5'd31 || best_qvalue !== 16'h0000 || best_ch_hops !== 16'hFFFF) begin
      errors++; $display("FAIL b2b_last_entry got found=%b idx=%0d q=%h ch=%h exp 1 31 0000 ffff", found, best_idx, best_qvalue, best_ch_hops);
    end
    clear_table();
    t_valid[0] = 1'b1; t_q[0] = 16'hFFFF; t_ch[0] = 16'd0;
    t_valid[1] = 1'b1; t_q[1] = 16'hFFFE; t_ch[1] = 16'd0;
    @(posedge clk); #1;
    do_scan(cyc, to);
    checks++; if (to || cyc != D) begin
      errors++; $display("FAIL b2b_latency got %0d exp %0d", cyc, D);
    end
    checks++; if (found !== 1'b1 || best_idx !== 5'd0 || best_id !== 16'h1000 || best_qvalue !== 16'hFFFF || best_ch_hops !== 16'd0) begin
      errors++; $display("FAIL b2b_first_entry got found=%b idx=%0d id=%h q=%h ch=%0d exp 1 0 1000 ffff 0", found, best_idx, best_id, best_qvalue, best_ch_hops);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_scan();
    test_tie();
    test_abort();
    test_start_ignored();
    test_none();
    test_energy();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
